mdiv_sequencer: RTL

Iterative multiply/divide sequencer that owns the architectural HI/LO registers of the integer pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the M1 stage and runs a radix-2 shift-add multiply or restoring divide, one bit per cycle. It drives BUSY, which the hazard unit combines with MFHI/MFLO detection at M1 to stall the front end until the result is ready.

---
 rtl/mdiv_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mdiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with sign fix-up and write-back in a final cycle.
module mdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t                 state;
    logic                   is_div;
    logic                   is_signed;
    logic                   sign_a;
    logic                   sign_b;
    logic                   div_zero;
    logic [WIDTH-1:0]       opnd;
    logic [2*WIDTH-1:0]     acc;
    logic [CW-1:0]          cnt;

    logic                   op_arith;
    logic                   op_signed;
    logic [WIDTH-1:0]       abs_a;
    logic [WIDTH-1:0]       abs_b;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_diff;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix;
    logic [WIDTH-1:0]       rem_fix;

    assign busy      = (state != IDLE);
    assign op_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign abs_a     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // opnd holds the multiplicand for multiply and the divisor for divide
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    assign prod_fix  = (is_signed && (sign_a ^ sign_b)) ? -acc : acc;
    assign quo_fix   = (is_signed && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // A zero divisor leaves |dividend| in the remainder, so the sign fix restores SRC_A
    assign rem_fix   = (is_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            opnd      <= '0;
            acc       <= '0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && op_arith) begin
                        is_div    <= op[1];
                        is_signed <= op_signed;
                        sign_a    <= op_signed & src_a[WIDTH-1];
                        sign_b    <= op_signed & src_b[WIDTH-1];
                        div_zero  <= op[1] && (src_b == '0);
                        opnd      <= op[1] ? abs_b : abs_a;
                        acc       <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        cnt       <= '0;
                        state     <= CALC;
                    end else if (start && op == OP_MTHI) begin
                        hi <= src_a;
                    end else if (start && op == OP_MTLO) begin
                        lo <= src_a;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc <= {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                                acc[WIDTH-2:0], div_ge};
                    end else if (acc[0]) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else begin
                        acc <= {1'b0, acc[2*WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        lo <= div_zero ? '1 : quo_fix;
                        hi <= rem_fix;
                    end else begin
                        lo <= prod_fix[WIDTH-1:0];
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
